// File: rtl/ee354_snake_body.sv
// Snake body tracker: circular buffer of segment cells, occupancy map and move FSM.
// Define SNAKE_WRAP_EN to make the grid toroidal instead of walled.
module ee354_snake_body #(
  parameter int unsigned GRID_W  = 15,
  parameter int unsigned GRID_H  = 15,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic                       Step,
  input  logic                       Dir_Valid,
  input  logic [1:0]                 Dir_In,
  input  logic [3:0]                 Apple_X,
  input  logic [3:0]                 Apple_Y,
  output logic [3:0]                 Head_X,
  output logic [3:0]                 Head_Y,
  output logic [3:0]                 Tail_X,
  output logic [3:0]                 Tail_Y,
  output logic [7:0]                 Length,
  output logic [GRID_W*GRID_H-1:0]   Occupancy,
  output logic                       Busy,
  output logic                       Ate,
  output logic                       Collision,
  output logic                       Win
);

  localparam int unsigned NumCells = GRID_W * GRID_H;
  localparam int unsigned PtrW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IdxW     = $clog2(NumCells);
  localparam int unsigned Cx       = GRID_W / 2;
  localparam int unsigned Cy       = GRID_H / 2;
  localparam logic [NumCells-1:0] One = NumCells'(1);
  localparam logic [NumCells-1:0] StartOcc = (One << (Cy * GRID_W + Cx)) |
                                             (One << ((Cy - 1) * GRID_W + Cx)) |
                                             (One << ((Cy - 2) * GRID_W + Cx));

  typedef enum logic [2:0] {StIdle, StEval, StCommit, StDead, StWon} state_e;

  state_e              state_q, state_d;
  logic [1:0]          dir_q, dir_d, pend_q, pend_d;
  logic [3:0]          head_x_q, head_x_d, head_y_q, head_y_d;
  logic [3:0]          tail_x_q, tail_x_d, tail_y_q, tail_y_d;
  logic [3:0]          nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
  logic [8:0]          len_q, len_d;
  logic [NumCells-1:0] occ_q, occ_d;
  logic [PtrW-1:0]     head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
  logic                grow_q, grow_d, ate_q, ate_d, col_q, col_d, win_q, win_d;
  logic [7:0]          body_q [MAX_LEN];
  logic [7:0]          body_d [MAX_LEN];

  logic [4:0]          nx5, ny5;
  logic                wall, hit, grow, is_tail;
  logic [IdxW-1:0]     nidx, cidx, tidx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  // Candidate next head, evaluated against the pending direction.
  always_comb begin
    nx5 = {1'b0, head_x_q};
    ny5 = {1'b0, head_y_q};
    unique case (pend_q)
      2'b00:   ny5 = ny5 + 5'd1;
      2'b01:   ny5 = ny5 - 5'd1;
      2'b10:   nx5 = nx5 - 5'd1;
      default: nx5 = nx5 + 5'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx5 >= 5'(GRID_W)) nx5 = (pend_q == 2'b10) ? 5'(GRID_W - 1) : 5'd0;
    if (ny5 >= 5'(GRID_H)) ny5 = (pend_q == 2'b01) ? 5'(GRID_H - 1) : 5'd0;
    wall = 1'b0;
`else
    wall = (nx5 >= 5'(GRID_W)) || (ny5 >= 5'(GRID_H));
`endif
    grow    = (nx5[3:0] == Apple_X) && (ny5[3:0] == Apple_Y);
    is_tail = (nx5[3:0] == tail_x_q) && (ny5[3:0] == tail_y_q);
    nidx    = IdxW'(ny5 * GRID_W + nx5);
    // The tail cell is free this move unless the snake is growing.
    hit     = !wall && occ_q[nidx] && !(is_tail && !grow);
    cidx    = IdxW'(nxt_y_q * GRID_W + nxt_x_q);
    tidx    = IdxW'(tail_y_q * GRID_W + tail_x_q);
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    tail_x_d   = tail_x_q;
    tail_y_d   = tail_y_q;
    nxt_x_d    = nxt_x_q;
    nxt_y_d    = nxt_y_q;
    len_d      = len_q;
    occ_d      = occ_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    grow_d     = grow_q;
    ate_d      = ate_q;
    col_d      = col_q;
    win_d      = win_q;
    body_d     = body_q;
    if (Enable) begin
      ate_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Dir_Valid && (Dir_In != {dir_q[1], ~dir_q[0]})) pend_d = Dir_In;
          if (Step) state_d = StEval;
        end
        StEval: begin
          dir_d   = pend_q;
          nxt_x_d = nx5[3:0];
          nxt_y_d = ny5[3:0];
          grow_d  = grow;
          if (wall || hit) begin
            col_d   = 1'b1;
            state_d = StDead;
          end else begin
            ate_d   = grow;
            state_d = StCommit;
          end
        end
        StCommit: begin
          head_ptr_d         = ptr_inc(head_ptr_q);
          body_d[head_ptr_d] = {nxt_x_q, nxt_y_q};
          head_x_d           = nxt_x_q;
          head_y_d           = nxt_y_q;
          if (grow_q) begin
            len_d = len_q + 9'd1;
          end else begin
            occ_d[tidx] = 1'b0;
            tail_ptr_d  = ptr_inc(tail_ptr_q);
            tail_x_d    = body_q[tail_ptr_d][7:4];
            tail_y_d    = body_q[tail_ptr_d][3:0];
          end
          occ_d[cidx] = 1'b1;
          if (len_d == 9'(MAX_LEN)) begin
            win_d   = 1'b1;
            state_d = StWon;
          end else begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      dir_q      <= 2'b00;
      pend_q     <= 2'b00;
      head_x_q   <= 4'(Cx);
      head_y_q   <= 4'(Cy);
      tail_x_q   <= 4'(Cx);
      tail_y_q   <= 4'(Cy - 2);
      nxt_x_q    <= '0;
      nxt_y_q    <= '0;
      len_q      <= 9'd3;
      occ_q      <= StartOcc;
      head_ptr_q <= PtrW'(2);
      tail_ptr_q <= '0;
      grow_q     <= 1'b0;
      ate_q      <= 1'b0;
      col_q      <= 1'b0;
      win_q      <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= '0;
      body_q[0]  <= {4'(Cx), 4'(Cy - 2)};
      body_q[1]  <= {4'(Cx), 4'(Cy - 1)};
      body_q[2]  <= {4'(Cx), 4'(Cy)};
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      tail_x_q   <= tail_x_d;
      tail_y_q   <= tail_y_d;
      nxt_x_q    <= nxt_x_d;
      nxt_y_q    <= nxt_y_d;
      len_q      <= len_d;
      occ_q      <= occ_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      grow_q     <= grow_d;
      ate_q      <= ate_d;
      col_q      <= col_d;
      win_q      <= win_d;
      body_q     <= body_d;
    end
  end

  assign Head_X    = head_x_q;
  assign Head_Y    = head_y_q;
  assign Tail_X    = tail_x_q;
  assign Tail_Y    = tail_y_q;
  assign Length    = len_q[7:0];
  assign Occupancy = occ_q;
  assign Busy      = (state_q == StEval) || (state_q == StCommit);
  assign Ate       = ate_q;
  assign Collision = col_q;
  assign Win       = win_q;

endmodule
